// File: rtl/gelu_exp_pkg.sv
// gelu_exp_pkg: shared fixed-point constants and segment LUTs for the GELU exponent datapath
package gelu_exp_pkg;
    localparam int Q         = 26;
    localparam int W         = 32;
    localparam int INT_WIDTH = 5;

    localparam logic signed [W-1:0] LOG2E = 32'h05C551D9;
    localparam logic signed [W-1:0] T_MAX = 32'h13FFFFFF;
    localparam logic signed [W-1:0] T_MIN = 32'hC0000000;

    typedef logic [2:0] seg_t;

    localparam logic [W-1:0] K_LUT [8] = '{
        32'h02E57078, 32'h03288B9B, 32'h0371B996, 32'h03C18722,
        32'h04188DB7, 32'h047774AE, 32'h04DEF287, 32'h054FCE46
    };

    localparam logic [W-1:0] B_LUT [8] = '{
        32'h04000000, 32'h03F79C9B, 32'h03E5511D, 32'h03C76408,
        32'h039BE0BD, 32'h03609063, 32'h0312F200, 32'h02B031B9
    };
endpackage

// File: rtl/exp_range_reduce_if.sv
// exp_range_reduce_if: operand input and EU-facing output handshake bundle
interface exp_range_reduce_if;
    import gelu_exp_pkg::*;
    logic                 valid_in;
    logic                 ready_in;
    logic [W-1:0]         x_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [INT_WIDTH-1:0] integer_part;
    logic [Q-1:0]         frac_part;
    logic [W-1:0]         k_coeff;
    logic [W-1:0]         b_intercept;
    logic                 sat_out;

    modport slave (
        input  valid_in, x_in, ready_out,
        output ready_in, valid_out, integer_part, frac_part, k_coeff, b_intercept, sat_out
    );

    modport master (
        output valid_in, x_in, ready_out,
        input  ready_in, valid_out, integer_part, frac_part, k_coeff, b_intercept, sat_out
    );
endinterface

// File: rtl/exp_seg_lut.sv
// exp_seg_lut: combinational fraction segment to {slope, intercept} lookup
module exp_seg_lut
    import gelu_exp_pkg::*;
(
    input  seg_t         seg,
    output logic [W-1:0] k,
    output logic [W-1:0] b
);
    assign k = K_LUT[seg];
    assign b = B_LUT[seg];
endmodule

// File: rtl/exp_range_reduce.sv
// exp_range_reduce: scale/clamp/split operand into EU integer, fraction and segment coefficients
// Define EXP_RANGE_LOG2E_EN to scale by log2(e) (e^x inputs); otherwise t = x_in (2^x inputs).
module exp_range_reduce
    import gelu_exp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    exp_range_reduce_if.slave io
);
    localparam logic signed [63:0] T_MAX_X = 64'(T_MAX);
    localparam logic signed [63:0] T_MIN_X = 64'(T_MIN);
    localparam int TW = Q + INT_WIDTH;

    logic                 en;
    logic signed [63:0]   x_ext;
    logic signed [63:0]   t_full;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [TW-1:0]        t_clamp;
    logic [W-1:0]         lut_k;
    logic [W-1:0]         lut_b;

    logic                 s1_valid_d, s1_valid_q;
    logic [TW-1:0]        s1_t_d, s1_t_q;
    logic                 s1_sat_d, s1_sat_q;
    logic                 s2_valid_d, s2_valid_q;
    logic [INT_WIDTH-1:0] s2_int_d, s2_int_q;
    logic [Q-1:0]         s2_frac_d, s2_frac_q;
    logic [W-1:0]         s2_k_d, s2_k_q;
    logic [W-1:0]         s2_b_d, s2_b_q;
    logic                 s2_sat_d, s2_sat_q;

    assign en          = !(s2_valid_q && !io.ready_out);
    assign io.ready_in = en;

    // Scale (optional), then clamp on the full-width value so large products cannot wrap into range
    always_comb begin
        x_ext   = {{32{io.x_in[W-1]}}, io.x_in};
`ifdef EXP_RANGE_LOG2E_EN
        t_full  = (x_ext * 64'(LOG2E)) >>> Q;
`else
        t_full  = x_ext;
`endif
        sat_hi  = t_full > T_MAX_X;
        sat_lo  = t_full < T_MIN_X;
        t_clamp = sat_hi ? T_MAX[TW-1:0] : sat_lo ? T_MIN[TW-1:0] : t_full[TW-1:0];
    end

    exp_seg_lut u_lut (
        .seg (s1_t_q[Q-1:Q-3]),
        .k   (lut_k),
        .b   (lut_b)
    );

    // Both stages advance together; data registers load only with a valid item so outputs stay meaningful
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_t_d     = s1_t_q;
        s1_sat_d   = s1_sat_q;
        s2_valid_d = s2_valid_q;
        s2_int_d   = s2_int_q;
        s2_frac_d  = s2_frac_q;
        s2_k_d     = s2_k_q;
        s2_b_d     = s2_b_q;
        s2_sat_d   = s2_sat_q;
        if (en) begin
            s1_valid_d = io.valid_in;
            s1_t_d     = io.valid_in ? t_clamp : s1_t_q;
            s1_sat_d   = io.valid_in ? (sat_hi || sat_lo) : s1_sat_q;
            s2_valid_d = s1_valid_q;
            s2_int_d   = s1_valid_q ? s1_t_q[TW-1:Q] : s2_int_q;
            s2_frac_d  = s1_valid_q ? s1_t_q[Q-1:0] : s2_frac_q;
            s2_k_d     = s1_valid_q ? lut_k : s2_k_q;
            s2_b_d     = s1_valid_q ? lut_b : s2_b_q;
            s2_sat_d   = s1_valid_q ? s1_sat_q : s2_sat_q;
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight items
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_t_q     <= '0;
            s1_sat_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_int_q   <= '0;
            s2_frac_q  <= '0;
            s2_k_q     <= '0;
            s2_b_q     <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_t_q     <= s1_t_d;
            s1_sat_q   <= s1_sat_d;
            s2_valid_q <= s2_valid_d;
            s2_int_q   <= s2_int_d;
            s2_frac_q  <= s2_frac_d;
            s2_k_q     <= s2_k_d;
            s2_b_q     <= s2_b_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign io.valid_out    = s2_valid_q;
    assign io.integer_part = s2_int_q;
    assign io.frac_part    = s2_frac_q;
    assign io.k_coeff      = s2_k_q;
    assign io.b_intercept  = s2_b_q;
    assign io.sat_out      = s2_sat_q;
endmodule

// File: tb/tb_exp_range_reduce.sv
// tb_exp_range_reduce: directed vector table plus stall and reset sequences for exp_range_reduce
module tb_exp_range_reduce;
    typedef struct {
        logic [31:0] x;
        logic [4:0]  i;
        logic [25:0] f;
        logic [31:0] k;
        logic [31:0] b;
        logic        s;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vt[$];
    logic [95:0] rx[$];

    exp_range_reduce_if ifc ();

    exp_range_reduce dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pk(input vec_t v);
        return {v.i, v.f, v.k, v.b, v.s};
    endfunction

    function automatic logic [95:0] dut_out();
        return {ifc.integer_part, ifc.frac_part, ifc.k_coeff, ifc.b_intercept, ifc.sat_out};
    endfunction

    always @(negedge clk)
        if (!rst && ifc.valid_out && ifc.ready_out) rx.push_back(dut_out());

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] x);
        bit ok = 0;
        ifc.valid_in = 1'b1;
        ifc.x_in     = x;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = ifc.ready_in;
            @(posedge clk);
            #1;
        end
        ifc.valid_in = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout x=%h ready_in stayed 0", x);
        end
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < 100 && rx.size() < n; c++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef EXP_RANGE_LOG2E_EN
        vt.push_back('{x:32'h04000000, i:5'h01, f:26'h1C551D9, k:32'h03C18722, b:32'h03C76408, s:1'b0});
        vt.push_back('{x:32'hFC000000, i:5'h1E, f:26'h23AAE27, k:32'h04188DB7, b:32'h039BE0BD, s:1'b0});
`else
        vt.push_back('{x:32'h00800000, i:5'h00, f:26'h0800000, k:32'h03288B9B, b:32'h03F79C9B, s:1'b0});
        vt.push_back('{x:32'hFF800000, i:5'h1F, f:26'h3800000, k:32'h054FCE46, b:32'h02B031B9, s:1'b0});
        vt.push_back('{x:32'h13FFFFFF, i:5'h04, f:26'h3FFFFFF, k:32'h054FCE46, b:32'h02B031B9, s:1'b0});
        vt.push_back('{x:32'hC0000000, i:5'h10, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b0});
        vt.push_back('{x:32'h0A6AAAAA, i:5'h02, f:26'h26AAAAA, k:32'h04188DB7, b:32'h039BE0BD, s:1'b0});
        vt.push_back('{x:32'hFC000000, i:5'h1F, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b0});
        vt.push_back('{x:32'h02000000, i:5'h00, f:26'h2000000, k:32'h04188DB7, b:32'h039BE0BD, s:1'b0});
`endif
        vt.push_back('{x:32'h00000000, i:5'h00, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b0});
        vt.push_back('{x:32'h1C000000, i:5'h04, f:26'h3FFFFFF, k:32'h054FCE46, b:32'h02B031B9, s:1'b1});
        vt.push_back('{x:32'hB0000000, i:5'h10, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b1});
        vt.push_back('{x:32'h7FFFFFFF, i:5'h04, f:26'h3FFFFFF, k:32'h054FCE46, b:32'h02B031B9, s:1'b1});
        vt.push_back('{x:32'h80000000, i:5'h10, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b1});
        vt.push_back('{x:32'h14000000, i:5'h04, f:26'h3FFFFFF, k:32'h054FCE46, b:32'h02B031B9, s:1'b1});
        vt.push_back('{x:32'hBFFFFFFF, i:5'h10, f:26'h0000000, k:32'h02E57078, b:32'h04000000, s:1'b1});

        ifc.valid_in  = 1'b0;
        ifc.x_in      = '0;
        ifc.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_state", {ifc.valid_out, ifc.ready_in, dut_out()}, {1'b0, 1'b1, 96'b0});
        @(posedge clk);
        #1;

        send(vt[0].x);
        @(negedge clk);
        chk("latency_s1", ifc.valid_out, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("latency_s2", {ifc.valid_out, dut_out()}, {1'b1, pk(vt[0])});
        @(posedge clk);
        #1;
        rx.delete();

        foreach (vt[n]) send(vt[n].x);
        drain(vt.size());
        chk("stream_count", rx.size(), vt.size());
        for (int n = 0; n < vt.size() && n < rx.size(); n++)
            chk($sformatf("vec%0d_x%h", n, vt[n].x), rx[n], pk(vt[n]));

        rx.delete();
        ifc.ready_out = 1'b0;
        fork
            begin
                send(vt[1].x);
                send(vt[2].x);
                send(vt[3].x);
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (ifc.valid_out) break;
                end
                chk("stall_valid", ifc.valid_out, 1'b1);
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    chk($sformatf("stall_hold%0d", c), {ifc.ready_in, dut_out()}, {1'b0, pk(vt[1])});
                end
                @(posedge clk);
                #1 ifc.ready_out = 1'b1;
            end
        join
        drain(3);
        chk("stall_count", rx.size(), 3);
        for (int n = 0; n < 3 && n < rx.size(); n++)
            chk($sformatf("stall_order%0d", n), rx[n], pk(vt[n + 1]));

        rx.delete();
        ifc.ready_out = 1'b0;
        send(vt[4].x);
        send(vt[5].x);
        ifc.valid_in = 1'b1;
        ifc.x_in     = vt[6].x;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ifc.valid_in = 1'b0;
        @(negedge clk);
        chk("rst_flush", {ifc.valid_out, ifc.ready_in, dut_out()}, {1'b0, 1'b1, 96'b0});
        @(posedge clk);
        #1 ifc.ready_out = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
